// File: rtl/secp256k1_mod_inv_seq.sv
// Sequential binary extended-Euclid inverter mod the secp256k1 prime, one step per clock.
// Define MOD_INV_CYCLE_CNT_EN to add the out_steps / max_steps step-count outputs.
module secp256k1_mod_inv_seq #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned MAX_ITER = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_inv,
`ifdef MOD_INV_CYCLE_CNT_EN
    output logic [9:0]       out_steps,
    output logic [9:0]       max_steps,
`endif
    output logic             out_err
);

    localparam logic [WIDTH-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   u_q, u_d, v_q, v_d;
    logic [WIDTH-1:0]   x1_q, x1_d, x2_q, x2_d;
    logic [WIDTH-1:0]   inv_q, inv_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // x/2 mod p: odd x is made even by adding p, sum kept at WIDTH+1 bits.
    function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] msub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (a - b + P);
    endfunction

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        inv_d   = inv_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    u_d     = (in_a >= P) ? (in_a - P) : in_a;
                    v_d     = P;
                    x1_d    = WIDTH'(1);
                    x2_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (u_q == WIDTH'(1)) begin
                    inv_d   = x1_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (v_q == WIDTH'(1)) begin
                    inv_d   = x2_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (u_q == '0 || cnt_q == CNT_W'(MAX_ITER)) begin
                    inv_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!u_q[0]) begin
                        u_d  = u_q >> 1;
                        x1_d = half(x1_q);
                    end else if (!v_q[0]) begin
                        v_d  = v_q >> 1;
                        x2_d = half(x2_q);
                    end else if (u_q >= v_q) begin
                        u_d  = u_q - v_q;
                        x1_d = msub(x1_q, x2_q);
                    end else begin
                        v_d  = v_q - u_q;
                        x2_d = msub(x2_q, x1_q);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            inv_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // in_ready is held low during reset even though the state register already reads IDLE.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_inv   = inv_q;
    assign out_err   = err_q;

`ifdef MOD_INV_CYCLE_CNT_EN
    logic [9:0] steps_q, max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_q <= '0;
            max_q   <= '0;
        end else begin
            if (state_q == S_RUN && state_d == S_DONE) steps_q <= cnt_q;
            if (out_valid && out_ready && steps_q > max_q) max_q <= steps_q;
        end
    end

    assign out_steps = steps_q;
    assign max_steps = max_q;
`endif

endmodule

// File: tb/tb_secp256k1_mod_inv_seq.sv
// Randomised self-checking bench for secp256k1_mod_inv_seq against a Fermat-inverse model.
module tb_secp256k1_mod_inv_seq;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int LAT_LIMIT = 1000;
    localparam int N_RAND    = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, out_err;
    logic [255:0] in_a, out_inv;
`ifdef MOD_INV_CYCLE_CNT_EN
    logic [9:0]   out_steps, max_steps;
    logic [9:0]   max_seen;
`endif

    int checks   = 0;
    int failures = 0;

    secp256k1_mod_inv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
`ifdef MOD_INV_CYCLE_CNT_EN
        .out_steps (out_steps),
        .max_steps (max_steps),
`endif
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod;
        prod = ({256'b0, a} * {256'b0, b}) % {256'b0, P};
        return prod[255:0];
    endfunction

    // Reference inverse by Fermat: a^(p-2) mod p.
    function automatic logic [255:0] ref_inv(input logic [255:0] a);
        logic [255:0] r, b, e;
        r = 256'd1;
        b = a % P;
        e = P - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, b);
            b = mulmod(b, b);
        end
        return r;
    endfunction

    // Accept one operand and wait (bounded) for out_valid; lat counts cycles from accept.
    task automatic start_and_wait(input logic [255:0] a, output int lat);
        check("accept_ready", {255'b0, in_ready}, 256'd1);
        in_a     = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("valid_timeout", 256'd0, 256'd1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`ifdef MOD_INV_CYCLE_CNT_EN
        if (out_steps > max_seen) max_seen = out_steps;
        check("max_steps", {246'b0, max_steps}, {246'b0, max_seen});
`endif
    endtask

    task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] exp_inv,
                          input logic exp_err, input int exp_lat);
        int lat;
        start_and_wait(a, lat);
        check({tag, "_inv"}, out_inv, exp_inv);
        check({tag, "_err"}, {255'b0, out_err}, {255'b0, exp_err});
        if (exp_lat > 0) check({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        finish_op();
    endtask

    initial begin
        logic [255:0] a, inv_hold;
        logic         err_hold, seen;
        int           lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
`ifdef MOD_INV_CYCLE_CNT_EN
        max_seen  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {255'b0, in_ready}, 256'd0);
        check("rst_out_valid", {255'b0, out_valid}, 256'd0);
        check("rst_out_inv", out_inv, 256'd0);
        check("rst_out_err", {255'b0, out_err}, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {255'b0, in_ready}, 256'd1);

        run_op("a1", 256'd1, 256'd1, 1'b0, 2);
        run_op("a2", 256'd2,
               256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18, 1'b0, 3);
        run_op("pm1", P - 256'd1, P - 256'd1, 1'b0, 0);
        run_op("pp1", P + 256'd1, 256'd1, 1'b0, 2);
        run_op("zero", 256'd0, 256'd0, 1'b1, 2);
        run_op("p", P, 256'd0, 1'b1, 2);

        start_and_wait(256'd3, lat);
        check("a3_ref", out_inv, ref_inv(256'd3));
        check("a3_prod", mulmod(256'd3, out_inv), 256'd1);
        check("a3_err", {255'b0, out_err}, 256'd0);

        // Backpressure: result must hold, operand offered meanwhile must be ignored.
        inv_hold = out_inv;
        err_hold = out_err;
        seen     = 1'b0;
        in_a     = 256'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_inv !== inv_hold || out_err !== err_hold || in_ready !== 1'b0 ||
                out_valid !== 1'b1) seen = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_stable", {255'b0, seen}, 256'd0);
        finish_op();
        check("bp_after_valid", {255'b0, out_valid}, 256'd0);
        check("bp_after_ready", {255'b0, in_ready}, 256'd1);

        for (int n = 0; n < N_RAND; n++) begin
            do begin
                for (int i = 0; i < 8; i++) a[i*32 +: 32] = $urandom;
            end while (a == '0 || a >= P);
            start_and_wait(a, lat);
            check("rnd_ref", out_inv, ref_inv(a));
            check("rnd_prod", mulmod(a, out_inv), 256'd1);
            check("rnd_err", {255'b0, out_err}, 256'd0);
`ifdef MOD_INV_CYCLE_CNT_EN
            check("rnd_steps", {246'b0, out_steps}, 256'(lat - 2));
`endif
            finish_op();
        end

        // Reset pulse mid-computation: everything clears and the operand is dropped.
        a = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1111_2222_3333_4444_5555_6666_7777_8888;
        in_a     = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {255'b0, in_ready}, 256'd0);
        check("mid_rst_valid", {255'b0, out_valid}, 256'd0);
        check("mid_rst_inv", out_inv, 256'd0);
        check("mid_rst_err", {255'b0, out_err}, 256'd0);
`ifdef MOD_INV_CYCLE_CNT_EN
        check("mid_rst_max", {246'b0, max_steps}, 256'd0);
        max_seen = '0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_stale_out", {255'b0, seen}, 256'd0);
        check("rst_recover_ready", {255'b0, in_ready}, 256'd1);
        run_op("after_rst", a, ref_inv(a), 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
